hwpe_ctrl_parity_scrubber: RTL and testbench
============================================

# hwpe_ctrl_parity_scrubber

Sequential parity checker and scheduler for the HWPE control register file. It walks the flattened regfile one 32-bit word per cycle, folds each word into an XOR signature and flags a fault when the folded 16-bit halves disagree. It serves two requesters: on-demand checks from the HWPE controller, issued before job start over a valid/ready handshake, and an internal periodic scrub timer. It sits beside the regfile in the control slave, replacing a wide single-cycle XOR tree with one 32-bit XOR per cycle.

## Interface
- `N_IO_REGS`, default 16: number of `hwpe_params` words.
- `N_GENERIC_REGS`, default 8: number of `generic_params` words.
- `SCRUB_PERIOD`, default 1024: idle cycles between internal scrub passes; 0 disables scrubbing.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `reg_file_i`  in  `ctrl_regfile_t`  register file contents being checked.
- `regfile_we_i`  in  1  a regfile write happens this cycle.
- `check_valid_i`  in  1  on-demand check request.
- `check_ready_o`  out  1  request accepted when high with `check_valid_i`.
- `result_valid_o`  out  1  on-demand result available.
- `result_ready_i`  in  1  result consumed.
- `result_fault_o`  out  1  result of the on-demand pass (1 = parity error).
- `fault_o`  out  1  sticky fault from any completed pass.
- `clear_fault_i`  in  1  clears `fault_o`.
- `busy_o`  out  1  a pass is in progress.

## Operation
- N = N_IO_REGS + N_GENERIC_REGS + 1 words.
- Word order: `hwpe_params[0..N_IO_REGS-1]`, then `generic_params[0..N_GENERIC_REGS-1]`, then `ext_data`.
- Fault condition: `|(acc[31:16] ^ acc[15:0])`, where `acc` is the XOR of all N words.
- States:
  - IDLE: `check_ready_o = 1`.
  - SCAN: walks the words; `busy_o = 1`.
  - RESULT: `result_valid_o = 1`.
- IDLE → SCAN on handshake (`ext` flag = 1), or when the scrub timer expires (`ext` = 0). An external request wins if both happen in the same cycle.
- SCAN, per cycle: `acc <= acc ^ word[idx]`, `idx++`; index width is `$clog2(N)`. Entry sets `idx = 0`, `acc = 0`.
- SCAN, last word (`idx == N-1`): compute `f = fault(acc ^ word[N-1])` combinationally.
  - `ext` = 1: go to RESULT with `result_fault_o <= f`.
  - `ext` = 0: go to IDLE.
  - In both cases `fault_o` is set if `f`.
- `regfile_we_i` high in any SCAN cycle, including the last: restart the pass (`idx = 0`, `acc = 0`), no result, `fault_o` untouched. Continuous writes starve the pass by design; software must stop writing.
- `regfile_we_i` in IDLE or RESULT: ignored; the RESULT value is already latched.
- RESULT: hold `result_fault_o` stable until `result_ready_i`, then go to IDLE.
- External request arriving during an internal scrub: `check_ready_o` stays low until IDLE.
- `fault_o`: set by a faulty pass completion, cleared by `clear_fault_i`; set wins if both occur in the same cycle.
- Scrub timer:
  - Counts only in IDLE; held in SCAN and RESULT.
  - Reset to 0 on every pass completion and on handshake.
  - Expires at `SCRUB_PERIOD-1`.
  - Never expires when `SCRUB_PERIOD = 0`.

## Timing
- Reset values:
  - `check_ready_o = 1` (state IDLE).
  - `result_valid_o = 0`, `result_fault_o = 0`, `fault_o = 0`, `busy_o = 0`.
  - Timer = 0, `acc = 0`, `idx = 0`.
- Handshake at cycle 0 → SCAN during cycles 1..N → `result_valid_o` high from cycle N+1.
- With `result_ready_i` high in cycle N+1, the next request can be accepted in cycle N+2.
- `fault_o` updates in the same cycle `result_valid_o` rises (N+1). For internal passes it updates N+1 cycles after expiry.
- All outputs are registered or decoded from state; no combinational path from `reg_file_i` to any output.
- Reset asserted mid-pass aborts immediately to the reset values; no partial result is presented.
- Handshakes follow valid/ready rules: `result_valid_o` and `result_fault_o` stay stable until accepted, with no dependency of valid on ready.

## Structure
- Add to `hwpe_ctrl_package`:
  - state typedef `parity_scrub_state_e` (IDLE, SCAN, RESULT);
  - the fault-fold function `parity_fold_fault(logic [31:0])`.
- Sub-module `hwpe_ctrl_regfile_word_mux` (parameters `N_IO_REGS`, `N_GENERIC_REGS`): flattens `ctrl_regfile_t` and selects `word[idx]` combinationally. The FSM, accumulator, timer and sticky flag live in the top module.

## Test plan
- Regfile with a correct signature (16+8+1 words), on-demand request → `result_valid_o` at cycle 26, `result_fault_o = 0`, `fault_o = 0`.
- Flip bit 5 of `generic_params[3]`, request → `result_fault_o = 1`, `fault_o = 1`; `clear_fault_i` → `fault_o = 0` next cycle.
- Pulse `regfile_we_i` at SCAN cycle 10 → pass restarts; result arrives 25 cycles after the write cycle, plus 1.
- `SCRUB_PERIOD = 16`, corrupted regfile, no requests → `busy_o` after 16 idle cycles, `fault_o = 1` 26 cycles after expiry, `result_valid_o` stays 0.
- Timer expiry and `check_valid_i` in the same cycle → external pass runs and `result_valid_o` rises; `result_ready_i` low for 5 cycles → `result_fault_o` stable and `check_ready_o = 0` throughout.
- `rst_ni` low at SCAN cycle 7 → all outputs return to reset values; a subsequent request completes normally.

Source files
------------

// File: rtl/hwpe_ctrl_package.sv
// Shared types for the HWPE control slave: register file layout, the
// parity scrubber state encoding and the signature fold used to flag faults.
package hwpe_ctrl_package;

    localparam int unsigned REGFILE_N_MAX_IO_REGS      = 48;
    localparam int unsigned REGFILE_N_MAX_GENERIC_REGS = 8;

    typedef struct packed {
        logic [REGFILE_N_MAX_IO_REGS-1:0][31:0]      hwpe_params;
        logic [REGFILE_N_MAX_GENERIC_REGS-1:0][31:0] generic_params;
        logic [31:0]                                 ext_data;
    } ctrl_regfile_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        RESULT = 2'd2
    } parity_scrub_state_e;

    // A healthy register file has an XOR signature whose 16-bit halves match.
    function automatic logic parity_fold_fault(logic [31:0] acc);
        return |(acc[31:16] ^ acc[15:0]);
    endfunction

endpackage

// File: rtl/hwpe_ctrl_regfile_word_mux.sv
// Flattens the control register file into a word list
// (hwpe_params, generic_params, ext_data) and selects one word by index.
module hwpe_ctrl_regfile_word_mux
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned N_IO_REGS      = 16,
    parameter int unsigned N_GENERIC_REGS = 8,
    localparam int unsigned N_WORDS       = N_IO_REGS + N_GENERIC_REGS + 1,
    localparam int unsigned IDX_W         = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  ctrl_regfile_t    reg_file_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [31:0]      word_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    logic [31:0] words [N_WORDS];
    // Words of the register file that are not part of the walk.
    logic        unused_regfile_bits;

    assign unused_regfile_bits = ^reg_file_i;

    for (genvar i = 0; i < N_IO_REGS; i++) begin : g_io
        assign words[i] = reg_file_i.hwpe_params[i];
    end

    for (genvar i = 0; i < N_GENERIC_REGS; i++) begin : g_generic
        assign words[N_IO_REGS + i] = reg_file_i.generic_params[i];
    end

    assign words[N_WORDS-1] = reg_file_i.ext_data;

    // Indices past the last word cannot occur during a walk; read them as zero.
    assign word_o = (idx_i <= LAST_IDX) ? words[idx_i] : 32'h0;

endmodule

// File: rtl/hwpe_ctrl_parity_scrubber.sv
// Sequential parity checker for the HWPE control register file. One word is
// folded into a running XOR signature per cycle; a pass is started either by
// the controller (on-demand, result returned) or by an idle-time scrub timer
// (result only feeds the sticky fault flag).
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high. check_ready_o is decoded from state only. result_valid_o does not
// depend on result_ready_i, and result_valid_o/result_fault_o hold steady
// until the result is accepted.
module hwpe_ctrl_parity_scrubber
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned N_IO_REGS      = 16,
    parameter int unsigned N_GENERIC_REGS = 8,
    parameter int unsigned SCRUB_PERIOD   = 1024
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  ctrl_regfile_t reg_file_i,
    input  logic          regfile_we_i,
    input  logic          check_valid_i,
    output logic          check_ready_o,
    output logic          result_valid_o,
    input  logic          result_ready_i,
    output logic          result_fault_o,
    output logic          fault_o,
    input  logic          clear_fault_i,
    output logic          busy_o
);

    localparam int unsigned N_WORDS = N_IO_REGS + N_GENERIC_REGS + 1;
    localparam int unsigned IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int unsigned TMR_W   = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((SCRUB_PERIOD > 0) ? SCRUB_PERIOD - 1 : 0);
    localparam logic             SCRUB_EN = (SCRUB_PERIOD != 0);

    parity_scrub_state_e state_q, state_d;
    logic                ext_q, ext_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [31:0]         acc_q, acc_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                result_fault_q, result_fault_d;
    logic                fault_q, fault_d;

    logic [31:0]         word;
    logic [31:0]         acc_next;
    logic                pass_fault;
    logic                fault_set;

    hwpe_ctrl_regfile_word_mux #(
        .N_IO_REGS      (N_IO_REGS),
        .N_GENERIC_REGS (N_GENERIC_REGS)
    ) i_word_mux (
        .reg_file_i (reg_file_i),
        .idx_i      (idx_q),
        .word_o     (word)
    );

    assign acc_next   = acc_q ^ word;
    assign pass_fault = parity_fold_fault(acc_next);

    // Next-state logic: request arbitration, word walk, result hold, scrub timer.
    always_comb begin
        state_d        = state_q;
        ext_d          = ext_q;
        idx_d          = idx_q;
        acc_d          = acc_q;
        timer_d        = timer_q;
        result_fault_d = result_fault_q;
        fault_set      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (check_valid_i) begin
                    // External request beats a coincident timer expiry.
                    state_d = SCAN;
                    ext_d   = 1'b1;
                    idx_d   = '0;
                    acc_d   = '0;
                    timer_d = '0;
                end else if (SCRUB_EN && (timer_q == TMR_LAST)) begin
                    state_d = SCAN;
                    ext_d   = 1'b0;
                    idx_d   = '0;
                    acc_d   = '0;
                end else if (SCRUB_EN) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SCAN: begin
                if (regfile_we_i) begin
                    // Contents moved under us: the partial signature is stale.
                    idx_d = '0;
                    acc_d = '0;
                end else if (idx_q == LAST_IDX) begin
                    fault_set = pass_fault;
                    timer_d   = '0;
                    idx_d     = '0;
                    acc_d     = '0;
                    if (ext_q) begin
                        state_d        = RESULT;
                        result_fault_d = pass_fault;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                    acc_d = acc_next;
                end
            end
            RESULT: begin
                if (result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky fault: a faulty completion outranks a same-cycle clear.
    always_comb begin
        fault_d = fault_q;
        if (fault_set) begin
            fault_d = 1'b1;
        end else if (clear_fault_i) begin
            fault_d = 1'b0;
        end
    end

    // State and datapath registers; reset aborts any pass in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            ext_q          <= 1'b0;
            idx_q          <= '0;
            acc_q          <= '0;
            timer_q        <= '0;
            result_fault_q <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            ext_q          <= ext_d;
            idx_q          <= idx_d;
            acc_q          <= acc_d;
            timer_q        <= timer_d;
            result_fault_q <= result_fault_d;
            fault_q        <= fault_d;
        end
    end

    assign check_ready_o  = (state_q == IDLE);
    assign busy_o         = (state_q == SCAN);
    assign result_valid_o = (state_q == RESULT);
    assign result_fault_o = result_fault_q;
    assign fault_o        = fault_q;

endmodule

// File: tb/tb_hwpe_ctrl_parity_scrubber.sv
// Directed bench for the parity scrubber with a whole-regfile reference model.
module tb_hwpe_ctrl_parity_scrubber;
    import hwpe_ctrl_package::*;

    localparam int N_IO    = 16;
    localparam int N_GEN   = 8;
    localparam int N_WORDS = N_IO + N_GEN + 1;
    localparam int PERIOD  = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ctrl_regfile_t rf;
    logic we, check_valid, result_ready, clear_fault;
    logic check_ready, result_valid, result_fault, fault, busy;

    int total = 0;
    int bad   = 0;

    hwpe_ctrl_parity_scrubber #(
        .N_IO_REGS      (N_IO),
        .N_GENERIC_REGS (N_GEN),
        .SCRUB_PERIOD   (PERIOD)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .reg_file_i     (rf),
        .regfile_we_i   (we),
        .check_valid_i  (check_valid),
        .check_ready_o  (check_ready),
        .result_valid_o (result_valid),
        .result_ready_i (result_ready),
        .result_fault_o (result_fault),
        .fault_o        (fault),
        .clear_fault_i  (clear_fault),
        .busy_o         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic report_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_fault(ctrl_regfile_t r);
        logic [31:0] x;
        x = 32'h0;
        for (int i = 0; i < N_IO; i++)  x = x ^ r.hwpe_params[i];
        for (int i = 0; i < N_GEN; i++) x = x ^ r.generic_params[i];
        x = x ^ r.ext_data;
        return (x >> 16) != (x & 32'hFFFF);
    endfunction

    function automatic ctrl_regfile_t good_rf();
        ctrl_regfile_t r;
        logic [31:0]   x;
        r = '0;
        x = 32'h0;
        for (int i = 0; i < N_IO; i++) begin
            r.hwpe_params[i] = $urandom;
            x = x ^ r.hwpe_params[i];
        end
        for (int i = 0; i < N_GEN; i++) begin
            r.generic_params[i] = $urandom;
            x = x ^ r.generic_params[i];
        end
        r.ext_data = x ^ 32'hA5C3_A5C3;
        return r;
    endfunction

    // Model state: 0 idle, 1 walking (m_left words still to fold), 2 result held.
    int m_mode, m_left, m_timer;
    bit m_ext, m_res, m_fault;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= 0;
            m_left  <= 0;
            m_timer <= 0;
            m_ext   <= 1'b0;
            m_res   <= 1'b0;
            m_fault <= 1'b0;
        end else begin
            if (clear_fault) m_fault <= 1'b0;
            case (m_mode)
                0: begin
                    if (check_valid) begin
                        m_mode <= 1; m_ext <= 1'b1; m_left <= N_WORDS; m_timer <= 0;
                    end else if (m_timer == PERIOD - 1) begin
                        m_mode <= 1; m_ext <= 1'b0; m_left <= N_WORDS;
                    end else begin
                        m_timer <= m_timer + 1;
                    end
                end
                1: begin
                    if (we) begin
                        m_left <= N_WORDS;
                    end else if (m_left == 1) begin
                        m_timer <= 0;
                        if (ref_fault(rf)) m_fault <= 1'b1;
                        if (m_ext) begin
                            m_mode <= 2;
                            m_res  <= ref_fault(rf);
                        end else begin
                            m_mode <= 0;
                        end
                    end else begin
                        m_left <= m_left - 1;
                    end
                end
                default: if (result_ready) m_mode <= 0;
            endcase
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic [0:0] exp_q[$];
    logic       prev_rv;

    always @(negedge clk) begin
        if (rst_n) begin
            check("m_check_ready", check_ready, m_mode == 0);
            check("m_busy", busy, m_mode == 1);
            check("m_result_valid", result_valid, m_mode == 2);
            check("m_fault", fault, m_fault);
            if (m_mode == 2) check("m_result_fault", result_fault, m_res);
            if (result_valid && !prev_rv) begin
                if (exp_q.size() == 0) report_fail("sb_unexpected_result");
                else check("sb_result", result_fault, exp_q.pop_front());
            end
        end
        prev_rv <= rst_n ? result_valid : 1'b0;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    // mod_at_we: 0 keep regfile, 1 rewrite with a good signature, 2 flip a bit.
    task automatic run_req(input int we_at, input int mod_at_we, input int exp_lat,
                           input bit exp_fault, input bit exp_fault_o, input int hold);
        int lat;
        bit seen;
        check("req_ready", check_ready, 1);
        check_valid = 1'b1;
        exp_q.push_back(exp_fault);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            tick();
            lat++;
            check_valid = 1'b0;
            if (result_valid) begin
                seen = 1'b1;
            end else begin
                we = (lat == we_at);
                if (lat == we_at && mod_at_we == 1) rf = good_rf();
                if (lat == we_at && mod_at_we == 2) rf.generic_params[3][5] = ~rf.generic_params[3][5];
            end
        end
        we = 1'b0;
        if (!seen) report_fail("result_timeout");
        check("latency", lat, exp_lat);
        check("result_fault", result_fault, exp_fault);
        check("fault_at_result", fault, exp_fault_o);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", result_valid, 1);
            check("hold_fault", result_fault, exp_fault);
            check("hold_ready", check_ready, 0);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("ready_after", check_ready, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n        = 1'b0;
        we           = 1'b0;
        check_valid  = 1'b0;
        result_ready = 1'b0;
        clear_fault  = 1'b0;
        rf           = good_rf();
        repeat (3) tick();
        check("rst_check_ready", check_ready, 1);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_fault", result_fault, 0);
        check("rst_fault", fault, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // Good signature: result at cycle 26, no fault.
        run_req(-1, 0, 26, 1'b0, 1'b0, 0);
        check("t1_fault", fault, 0);

        // Bit 5 of generic_params[3] flipped: fault reported and sticky.
        rf.generic_params[3][5] = ~rf.generic_params[3][5];
        run_req(-1, 0, 26, 1'b1, 1'b1, 0);
        check("t2_fault_sticky", fault, 1);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        check("t2_cleared", fault, 0);

        // Clear held across a faulty completion: the set wins.
        clear_fault = 1'b1;
        run_req(-1, 0, 26, 1'b1, 1'b1, 0);
        clear_fault = 1'b0;
        check("t2_clear_after", fault, 0);

        // Write at SCAN cycle 10 restarts the walk on the new (good) contents.
        run_req(10, 1, 36, 1'b0, 1'b0, 0);
        // Write on the last SCAN cycle discards that completion.
        run_req(25, 2, 51, 1'b1, 1'b1, 0);

        // Internal scrub on a corrupted regfile: no result, sticky fault only.
        clear_fault = 1'b1;
        for (int k = 1; k <= 41; k++) begin
            tick();
            clear_fault = 1'b0;
            if (k == 1)  check("t4_cleared", fault, 0);
            if (k == 15) check("t4_busy_before", busy, 0);
            if (k == 16) check("t4_busy_start", busy, 1);
            if (k == 40) check("t4_fault_before", fault, 0);
            if (k == 41) check("t4_fault_set", fault, 1);
            if (k == 41) check("t4_no_result", result_valid, 0);
        end

        // Request lands on the timer expiry cycle: external pass wins.
        repeat (15) tick();
        run_req(-1, 0, 26, 1'b1, 1'b1, 5);

        // Reset at SCAN cycle 7 aborts the pass.
        check_valid = 1'b1;
        tick();
        check_valid = 1'b0;
        repeat (6) tick();
        check("t6_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6_check_ready", check_ready, 1);
        check("t6_result_valid", result_valid, 0);
        check("t6_result_fault", result_fault, 0);
        check("t6_fault", fault, 0);
        check("t6_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        rf = good_rf();
        tick();
        run_req(-1, 0, 26, 1'b0, 1'b0, 0);

        repeat (2) tick();
        check("sb_leftover", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
